sram_128x16_ctrl: RTL and testbench

Synchronous valid/ready front-end that owns the SRAM_128x16 macro pins for one RNN weight/state bank.
- Registers each accepted request onto the macro's address, control and data pins.
- Captures read data returned by the macro.
- Returns read data in order through a backpressurable response queue.
- Sits between the layer sequencer (upstream requester) and the macro. The parent ties the macro CE pin to clk_i.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_rsp_fifo.sv | 50 +++++
 rtl/sram_128x16_ctrl.sv | 114 +++++++++++
 tb/tb_sram_128x16_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared widths, request/command types and the request-to-pin mapping for the SRAM_128x16 front-end.
package sram_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 16;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } sram_req_t;

  typedef struct packed {
    logic                   csb;
    logic                   web;
    logic [SRAM_ADDR_W-1:0] a;
    logic [SRAM_DATA_W-1:0] i;
  } sram_cmd_t;

  localparam sram_cmd_t SRAM_CMD_IDLE = '{csb: 1'b1, web: 1'b1, a: '0, i: '0};

  function automatic sram_cmd_t cmd_from_req(input sram_req_t r);
    sram_cmd_t c;
    c.csb = 1'b0;
    c.web = !r.we;
    c.a   = r.addr;
    c.i   = r.data;
    return c;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO; when empty, pop_data keeps presenting the most recently popped word.
module sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        last_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/sram_128x16_ctrl.sv
// Valid/ready front-end owning the SRAM_128x16 macro pins; in-order read responses with credit-based backpressure.
// Build option SRAM_CTRL_OEB_GATE_EN: drive OEB low only in the read-capture cycle (otherwise OEB is tied low).
module sram_128x16_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_v_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_v_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ADDR_W-1:0] sram_a_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic              sram_oeb_o,
  output logic [DATA_W-1:0] sram_i_o,
  input  logic [DATA_W-1:0] sram_o_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sram_req_t        req;
  sram_cmd_t        cmd_q;
  logic             pend_v;
  logic             accept;
  logic             rd_accept;
  logic             rsp_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] outstanding;

  assign req = '{we: req_we_i, addr: req_addr_i, data: req_data_i};

  // Credits cover every read from acceptance until pop, so the FIFO cannot overflow.
  assign req_ready_o = !reset_i && (outstanding < CNT_MAX);
  assign accept      = req_v_i && req_ready_o;
  assign rd_accept   = accept && !req_we_i;
  assign rsp_v_o     = !fifo_empty && !reset_i;
  assign rsp_pop     = rsp_v_o && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_q <= SRAM_CMD_IDLE;
    end else if (accept) begin
      cmd_q <= cmd_from_req(req);
    end else begin
      cmd_q.csb <= 1'b1;
      cmd_q.web <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_v <= 1'b0;
    end else begin
      pend_v <= !cmd_q.csb && cmd_q.web;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, rsp_pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(pend_v && fifo_full));
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (pend_v),
    .push_data (sram_o_i),
    .pop       (rsp_pop),
    .pop_data  (rsp_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Reset gates CSB immediately so a command still in the stage is not sampled by the macro.
  assign sram_csb_o = cmd_q.csb || reset_i;
  assign sram_web_o = cmd_q.web;
  assign sram_a_o   = cmd_q.a;
  assign sram_i_o   = cmd_q.i;

`ifdef SRAM_CTRL_OEB_GATE_EN
  assign sram_oeb_o = !pend_v;
`else
  assign sram_oeb_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_128x16_ctrl.sv
// Self-checking bench for sram_128x16_ctrl: macro model, transaction-level scoreboard, vector table and directed sequences.
module tb_sram_128x16_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_v_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [6:0]  req_addr_i;
  logic [15:0] req_data_i;
  logic        rsp_v_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_data_o;
  logic [6:0]  sram_a_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic        sram_oeb_o;
  logic [15:0] sram_i_o;
  logic [15:0] sram_o_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  sram_128x16_ctrl dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_v_i     (req_v_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_v_o     (rsp_v_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .sram_a_o    (sram_a_o),
    .sram_csb_o  (sram_csb_o),
    .sram_web_o  (sram_web_o),
    .sram_oeb_o  (sram_oeb_o),
    .sram_i_o    (sram_i_o),
    .sram_o_i    (sram_o_i)
  );

  // Macro model: samples pins on the rising edge, read data appears after that edge.
  logic [15:0] mac_mem [128];
  logic [15:0] mac_dout = 16'h0;
  always @(posedge clk_i) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) mac_mem[sram_a_o] <= sram_i_o;
      else             mac_dout <= mac_mem[sram_a_o];
    end
  end
  assign sram_o_i = sram_oeb_o ? 16'hDEAD : mac_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus queue of reads awaiting response, in acceptance order.
  typedef struct {
    int          acc_edge;
    logic [15:0] data;
  } pend_t;

  logic [15:0] ref_mem [128];
  pend_t       q[$];
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        m_fire, m_pop, prev_fire = 1'b0, prev_we = 1'b0;
  logic        have_last = 1'b0;
  logic [15:0] last_pop = 16'h0;
  logic [6:0]  last_a = 7'h0;
  logic [15:0] last_i = 16'h0;
  logic        rd_fire_1 = 1'b0, rd_fire_2 = 1'b0, rst_1 = 1'b0;
  logic        exp_v, exp_oeb_low;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("req_ready", req_ready_o, !reset_i && q.size() < 4);
      exp_v = !reset_i && q.size() > 0 && (q[0].acc_edge + 2 <= cyc);
      chk("rsp_v", rsp_v_o, exp_v);
      if (exp_v && rsp_v_o) chk("rsp_data", rsp_data_o, q[0].data);
      else if (!reset_i && !rsp_v_o && have_last) chk("rsp_hold", rsp_data_o, last_pop);

      if (reset_i)        chk("csb_rst", sram_csb_o, 1);
      else if (prev_fire) begin
        chk("csb_acc", sram_csb_o, 0);
        chk("web", sram_web_o, !prev_we);
      end else            chk("csb_idle", sram_csb_o, 1);
      chk("sram_a", sram_a_o, last_a);
      chk("sram_i", sram_i_o, last_i);

      exp_oeb_low = rd_fire_2 && !rst_1;
`ifdef SRAM_CTRL_OEB_GATE_EN
      chk("oeb", sram_oeb_o, !exp_oeb_low);
`else
      chk("oeb", sram_oeb_o, 0);
`endif

      m_fire = req_v_i && req_ready_o && !reset_i;
      m_pop  = rsp_v_o && rsp_ready_i && !reset_i;
      if (reset_i) begin
        q.delete();
        have_last = 1'b0;
      end else if (m_pop && q.size() > 0) begin
        last_pop  = q[0].data;
        have_last = 1'b1;
        void'(q.pop_front());
      end
      if (m_fire) begin
        if (req_we_i) ref_mem[req_addr_i] = req_data_i;
        else q.push_back('{acc_edge: cyc + 1, data: ref_mem[req_addr_i]});
      end

      rd_fire_2 = rd_fire_1;
      rd_fire_1 = m_fire && !req_we_i;
      rst_1     = reset_i;
      prev_fire = m_fire;
      prev_we   = req_we_i;
      if (reset_i) begin
        last_a = 7'h0;
        last_i = 16'h0;
      end else if (m_fire) begin
        last_a = req_addr_i;
        last_i = req_data_i;
      end
    end
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        rdy;
    logic        exp_ready;
    logic        exp_v;
    logic        chk_d;
    logic [15:0] exp_d;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [6:0] a, input logic [15:0] d,
                              input logic ev, input logic cd, input logic [15:0] ed);
    vec_t t;
    t.v = v; t.we = we; t.addr = a; t.data = d; t.rdy = 1'b1;
    t.exp_ready = 1'b1; t.exp_v = ev; t.chk_d = cd; t.exp_d = ed;
    return t;
  endfunction

  task automatic cyc_start;
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[16];
  int   acc;
  int   seen;
  logic [6:0] bp_addr;

  initial begin
    for (int k = 0; k < 128; k++) begin
      mac_mem[k] = 16'($urandom);
      ref_mem[k] = mac_mem[k];
    end
    reset_i = 1'b1; req_v_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0; rsp_ready_i = 1'b0;
    @(posedge clk_i);
    mon_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_a", sram_a_o, 0);
    chk("rst_i", sram_i_o, 0);
    chk("rst_web", sram_web_o, 1);
    chk("rst_csb", sram_csb_o, 1);
    chk("rst_rsp_v", rsp_v_o, 0);
    chk("rst_ready", req_ready_o, 1);
`ifdef SRAM_CTRL_OEB_GATE_EN
    chk("rst_oeb", sram_oeb_o, 1);
`else
    chk("rst_oeb", sram_oeb_o, 0);
`endif

    // Write-then-read hazard, then writes/reads across the 127 -> 0 boundary.
    tbl[0]  = mk(1, 1, 7'h05, 16'hBEEF, 0, 0, 16'h0);
    tbl[1]  = mk(1, 0, 7'h05, 16'h0000, 0, 0, 16'h0);
    tbl[2]  = mk(0, 0, 7'h00, 16'h0000, 0, 0, 16'h0);
    tbl[3]  = mk(0, 0, 7'h00, 16'h0000, 0, 0, 16'h0);
    tbl[4]  = mk(0, 0, 7'h00, 16'h0000, 1, 1, 16'hBEEF);
    tbl[5]  = mk(0, 0, 7'h00, 16'h0000, 0, 1, 16'hBEEF);
    tbl[6]  = mk(1, 1, 7'h7E, 16'h1111, 0, 1, 16'hBEEF);
    tbl[7]  = mk(1, 1, 7'h7F, 16'h2222, 0, 0, 16'h0);
    tbl[8]  = mk(1, 1, 7'h00, 16'h3333, 0, 0, 16'h0);
    tbl[9]  = mk(1, 0, 7'h7E, 16'h0000, 0, 0, 16'h0);
    tbl[10] = mk(1, 0, 7'h7F, 16'h0000, 0, 0, 16'h0);
    tbl[11] = mk(1, 0, 7'h00, 16'h0000, 0, 0, 16'h0);
    tbl[12] = mk(0, 0, 7'h00, 16'h0000, 1, 1, 16'h1111);
    tbl[13] = mk(0, 0, 7'h00, 16'h0000, 1, 1, 16'h2222);
    tbl[14] = mk(0, 0, 7'h00, 16'h0000, 1, 1, 16'h3333);
    tbl[15] = mk(0, 0, 7'h00, 16'h0000, 0, 1, 16'h3333);
    for (int n = 0; n < 16; n++) begin
      cyc_start();
      req_v_i = tbl[n].v; req_we_i = tbl[n].we; req_addr_i = tbl[n].addr;
      req_data_i = tbl[n].data; rsp_ready_i = tbl[n].rdy;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ready", n), req_ready_o, tbl[n].exp_ready);
      chk($sformatf("tbl%0d_rsp_v", n), rsp_v_o, tbl[n].exp_v);
      if (tbl[n].chk_d) chk($sformatf("tbl%0d_data", n), rsp_data_o, tbl[n].exp_d);
    end

    // Backpressure: six reads with the response side stalled, only four credits.
    acc = 0; bp_addr = 7'h00;
    for (int n = 0; n < 8; n++) begin
      cyc_start();
      req_v_i = 1'b1; req_we_i = 1'b0; req_addr_i = bp_addr; rsp_ready_i = 1'b0;
      @(negedge clk_i);
      if (req_ready_o) begin acc++; bp_addr++; end
    end
    chk("bp_accepts", acc, 4);
    chk("bp_ready_low", req_ready_o, 0);
    for (int n = 0; n < 20 && acc < 6; n++) begin
      cyc_start();
      req_v_i = 1'b1; req_we_i = 1'b0; req_addr_i = bp_addr; rsp_ready_i = 1'b1;
      @(negedge clk_i);
      if (req_ready_o) begin acc++; bp_addr++; end
    end
    chk("bp_total", acc, 6);
    cyc_start();
    req_v_i = 1'b0;
    for (int n = 0; n < 20 && q.size() != 0; n++) cyc_start();
    chk("bp_drain", q.size(), 0);

    // Reset arriving zero or one cycle after a read is accepted.
    for (int d = 0; d < 2; d++) begin
      cyc_start();
      req_v_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h10; req_data_i = 16'h5A5A + 16'(d);
      cyc_start();
      req_we_i = 1'b0;
      cyc_start();
      req_v_i = 1'b0;
      if (d == 1) cyc_start();
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("rstmid_csb", sram_csb_o, 1);
      chk("rstmid_ready", req_ready_o, 0);
      cyc_start();
      reset_i = 1'b0;
      seen = 0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk_i);
        if (rsp_v_o) seen++;
        cyc_start();
      end
      chk("rstmid_no_rsp", seen, 0);
      req_v_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h10;
      cyc_start();
      req_v_i = 1'b0;
      seen = 0;
      for (int n = 0; n < 6 && seen == 0; n++) begin
        @(negedge clk_i);
        if (rsp_v_o) begin
          seen = 1;
          chk("rstmid_read", rsp_data_o, 16'h5A5A + 16'(d));
        end
        cyc_start();
      end
      chk("rstmid_rsp_seen", seen, 1);
    end

    // Random traffic against the scoreboard; small address window to provoke same-address hazards.
    for (int n = 0; n < 400; n++) begin
      cyc_start();
      req_v_i     = 1'($urandom_range(0, 3) != 0);
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
      req_data_i  = 16'($urandom);
      rsp_ready_i = 1'($urandom_range(0, 9) < 7);
    end
    cyc_start();
    req_v_i = 1'b0; rsp_ready_i = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) cyc_start();
    chk("rand_drain", q.size(), 0);
    repeat (2) cyc_start();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
